// File: rtl/mem_wait_slave.sv
// Memory target for the mem_intf valid/ready bus with programmable wait states and four-phase release.
// Define MEM_RANGE_CHECK_EN to flag out-of-range accesses on err during the ready cycle.
module mem_wait_slave #(
  parameter int WIDTH       = 16,
  parameter int ADDR_WIDTH  = 6,
  parameter int DEPTH       = 48,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  wr_rd,
  input  logic                  valid,
  output logic [WIDTH-1:0]      rdata,
  output logic                  ready,
  output logic                  err,
  output logic                  busy
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_HOLD} state_t;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [WIDTH-1:0]        wdata_q;
  logic                    wr_q;
  logic [WIDTH-1:0]        rdata_q, rdata_d;
  logic                    ready_q;
  logic [WIDTH-1:0]        mem [DEPTH];

  logic [ADDR_WIDTH-1:0]   op_addr;
  logic [WIDTH-1:0]        op_wdata;
  logic                    op_wr;
  logic                    op_fire;
  logic                    in_range;
  logic                    mem_we;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_fire = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (valid) begin
          cnt_d = WAIT_LOAD;
          if (WAIT_CYCLES == 0) begin
            state_d = S_RESP;
            op_fire = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_RESP;
          op_fire = 1'b1;
        end
      end
      S_RESP:  state_d = S_HOLD;
      S_HOLD:  if (!valid) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // A zero-wait access fires on the accept edge itself, before the request
  // registers hold the captured copy, so it must use the live inputs.
  always_comb begin
    op_addr  = (state_q == S_IDLE) ? addr  : addr_q;
    op_wdata = (state_q == S_IDLE) ? wdata : wdata_q;
    op_wr    = (state_q == S_IDLE) ? wr_rd : wr_q;
    in_range = 32'(op_addr) < 32'(DEPTH);
    mem_we   = op_fire && op_wr && in_range;
    rdata_d  = rdata_q;
    if (op_fire && !op_wr) begin
      rdata_d = in_range ? mem[op_addr] : '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      ready_q <= op_fire;
      if (state_q == S_IDLE && valid) begin
        addr_q  <= addr;
        wdata_q <= wdata;
        wr_q    <= wr_rd;
      end
    end
  end

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[op_addr] <= op_wdata;
    end
  end

`ifdef MEM_RANGE_CHECK_EN
  logic err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= op_fire && !in_range;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign rdata = rdata_q;
  assign ready = ready_q;
  assign busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_wait_slave.sv
// Randomised self-checking bench: two instances (2 and 0 wait states) against a transaction-level memory model.
module tb_mem_wait_slave;

`ifdef MEM_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  addr = '0;
  logic [15:0] wdata = '0;
  logic        wr_rd = 1'b0;
  logic [1:0]  vld = '0;
  logic [15:0] rd0, rd1;
  logic [1:0]  rdy, er, bsy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] mdl     [2][64];
  bit          known   [2][64];
  logic [15:0] last_rd [2];

  always #5 clk = ~clk;

  mem_wait_slave #(.WIDTH(16), .ADDR_WIDTH(6), .DEPTH(48), .WAIT_CYCLES(2)) u_w2 (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .wr_rd(wr_rd), .valid(vld[0]),
    .rdata(rd0), .ready(rdy[0]), .err(er[0]), .busy(bsy[0])
  );

  mem_wait_slave #(.WIDTH(16), .ADDR_WIDTH(6), .DEPTH(48), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .wr_rd(wr_rd), .valid(vld[1]),
    .rdata(rd1), .ready(rdy[1]), .err(er[1]), .busy(bsy[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] rdv(input int s);
    return (s != 0) ? rd1 : rd0;
  endfunction

  // One complete bus transaction on instance s (0: two wait states, 1: zero wait).
  task automatic txn(input int s, input bit wr, input logic [5:0] a, input logic [15:0] d,
                     input int extra);
    int          lat;
    bit          oor;
    logic [15:0] exp_rd;
    oor = (a >= 6'd48);
    @(negedge clk);
    addr = a; wdata = d; wr_rd = wr; vld[s] = 1'b1;
    @(posedge clk); #1;
    addr = 6'($urandom); wdata = 16'($urandom); wr_rd = 1'($urandom);
    lat = 0;
    while (!rdy[s] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 32'(lat), (s != 0) ? 32'd0 : 32'd2);
    if (rdy[s]) begin
      check("err", 32'(er[s]), 32'(RC && oor));
      if (wr) begin
        if (!oor) begin
          mdl[s][a]   = d;
          known[s][a] = 1'b1;
        end
        exp_rd = last_rd[s];
      end else if (oor) begin
        exp_rd = '0;
      end else begin
        exp_rd = mdl[s][a];
      end
      last_rd[s] = exp_rd;
      check("rdata", 32'(rdv(s)), 32'(exp_rd));
    end
    @(posedge clk); #1;
    check("ready_width", 32'(rdy[s]), 32'd0);
    check("busy_hold", 32'(bsy[s]), 32'd1);
    for (int i = 0; i < extra; i++) begin
      @(posedge clk); #1;
      check("ready_held", 32'(rdy[s]), 32'd0);
      check("busy_held", 32'(bsy[s]), 32'd1);
    end
    @(negedge clk);
    vld[s] = 1'b0;
    @(posedge clk); #1;
    check("busy_fall", 32'(bsy[s]), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bit          wr;
    int          s;
    logic [5:0]  a;
    last_rd[0] = '0;
    last_rd[1] = '0;

    // Reset with valid asserted: nothing may be accepted.
    #1 rst = 1'b0;
    vld = 2'b11; addr = 6'd5; wr_rd = 1'b1; wdata = 16'hDEAD;
    repeat (3) begin
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) begin
        check("rst_ready", 32'(rdy[k]), 32'd0);
        check("rst_err", 32'(er[k]), 32'd0);
        check("rst_busy", 32'(bsy[k]), 32'd0);
        check("rst_rdata", 32'(rdv(k)), 32'd0);
      end
    end
    @(negedge clk);
    vld = '0;
    rst = 1'b1;
    @(posedge clk); #1;
    check("post_rst_busy", 32'(bsy[0]), 32'd0);

    txn(0, 1'b1, 6'd5, 16'hA5A5, 0);
    txn(0, 1'b0, 6'd5, 16'h0000, 0);
    txn(1, 1'b1, 6'd0, 16'h0001, 0);
    txn(1, 1'b0, 6'd0, 16'h0000, 0);
    txn(0, 1'b1, 6'd9, 16'hBEEF, 4);
    txn(0, 1'b0, 6'd9, 16'h0000, 4);

    // Out-of-range write must not alias onto 50 mod 48.
    txn(0, 1'b1, 6'd2, 16'h1357, 0);
    txn(0, 1'b1, 6'd50, 16'hFFFF, 0);
    txn(0, 1'b0, 6'd50, 16'h0000, 0);
    txn(0, 1'b0, 6'd2, 16'h0000, 0);
    txn(1, 1'b1, 6'd63, 16'h7777, 1);
    txn(1, 1'b0, 6'd63, 16'h0000, 0);

    // Reset while the write to 7 sits in WAIT: it must be dropped.
    txn(0, 1'b1, 6'd7, 16'h0000, 0);
    @(negedge clk);
    addr = 6'd7; wdata = 16'h1234; wr_rd = 1'b1; vld[0] = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", 32'(bsy[0]), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_busy_rst", 32'(bsy[0]), 32'd0);
    check("abort_rdata_rst", 32'(rd0), 32'd0);
    vld[0] = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      check("abort_no_ready", 32'(rdy[0]), 32'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    last_rd[0] = '0;
    last_rd[1] = '0;
    repeat (3) begin
      @(posedge clk); #1;
      check("abort_quiet", 32'(rdy[0]), 32'd0);
    end
    txn(0, 1'b0, 6'd7, 16'h0000, 0);

    for (int n = 0; n < 60; n++) begin
      s  = int'($urandom_range(0, 1));
      wr = 1'($urandom);
      a  = 6'($urandom_range(0, 63));
      if (!wr && a < 6'd48 && !known[s][a]) wr = 1'b1;
      txn(s, wr, a, 16'($urandom), int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
